mul_unit: RTL and testbench

Iterative radix-2 shift-add multiplier for the LEGv8 execute stage, covering MUL, UMULH and SMULH. It accepts two `WORD operands on a single-cycle start pulse and produces a `WORD result WIDTH+1 cycles later. The result is flagged by a one-cycle done pulse. The result drives the b_in leg of the 64-bit write-back `mux`, with the control input selecting between ALU result and multiplier result.

---
 rtl/mul_unit_pkg.sv | 27 ++
 rtl/mul_unit_if.sv | 24 ++
 rtl/mux.sv | 11 +
 rtl/mul_unit.sv | 126 ++++++++++++
 tb/tb_mul_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mul_unit_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// The control-unit decoder reuses mul_op_t.
package mul_unit_pkg;

   localparam int unsigned WORD_W    = 64;
   localparam int unsigned MUL_CNT_W = $clog2(WORD_W);

   typedef enum logic [1:0] {
      MUL   = 2'b00,
      UMULH = 2'b01,
      SMULH = 2'b10,
      RSVD  = 2'b11
   } mul_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } mul_state_t;

   // High-half ops select product[2W-1:W]; MUL and reserved take the low half.
   function automatic logic is_high_half(input mul_op_t op);
      return (op == UMULH) || (op == SMULH);
   endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Request/response bundle between the execute stage and the multiplier.
interface mul_unit_if
   import mul_unit_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_W
);
   logic             start;
   mul_op_t          op;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, a_in, b_in,
      input  busy, done, result
   );

   modport slave (
      input  start, op, a_in, b_in,
      output busy, done, result
   );
endinterface

// File: rtl/mux.sv
// Generic two-input word mux; sel_i = 1 picks b_i.
module mux #(
   parameter int unsigned WIDTH = 64
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sel_i,
   output logic [WIDTH-1:0] y_c
);
   assign y_c = sel_i ? b_i : a_i;
endmodule

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL / UMULH / SMULH.
// One product bit per RUN cycle, one FIX cycle for sign, result registered on entering DONE.
module mul_unit
   import mul_unit_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_W
) (
   input  logic       clk,
   input  logic       rst_n,
   mul_unit_if.slave  bus
);

   localparam int unsigned CNT_W  = (WIDTH == WORD_W) ? MUL_CNT_W : $clog2(WIDTH);
   localparam int unsigned PROD_W = 2 * WIDTH;

   mul_state_t        state_q,  state_d;
   mul_op_t           op_q,     op_d;
   logic [WIDTH-1:0]  mcand_q,  mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic              neg_q,    neg_d;
   logic [PROD_W-1:0] prod_q,   prod_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   logic              busy_q,   busy_d;
   logic              done_q,   done_d;
   logic [WIDTH-1:0]  result_q, result_d;

   logic              accept_c;
   logic              is_signed_c;
   logic [WIDTH:0]    sum_c;
   logic [WIDTH-1:0]  addend_c;
   logic [PROD_W-1:0] fixed_c;
   logic [WIDTH-1:0]  sel_result_c;

   // Partial-product add with carry-out, and the sign-corrected full product.
   assign addend_c     = mplier_q[0] ? mcand_q : '0;
   assign sum_c        = {1'b0, prod_q[PROD_W-1:WIDTH]} + {1'b0, addend_c};
   assign fixed_c      = neg_q ? -prod_q : prod_q;
   assign accept_c     = bus.start && ((state_q == IDLE) || (state_q == DONE));
   assign is_signed_c  = (bus.op == SMULH);

   mux #(
      .WIDTH (WIDTH)
   ) u_half_sel (
      .a_i   (fixed_c[WIDTH-1:0]),
      .b_i   (fixed_c[PROD_W-1:WIDTH]),
      .sel_i (is_high_half(op_q)),
      .y_c   (sel_result_c)
   );

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      prod_d   = prod_q;
      count_d  = count_q;
      result_d = result_q;
      done_d   = 1'b0;

      unique case (state_q)
         IDLE: ;
         RUN: begin
            prod_d   = {sum_c, prod_q[WIDTH-1:1]};
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CNT_W'(1);
            if (count_q == CNT_W'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            prod_d   = fixed_c;
            result_d = sel_result_c;
            done_d   = 1'b1;
            state_d  = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // An accepted start overrides the IDLE/DONE defaults above.
      if (accept_c) begin
         op_d     = bus.op;
         mcand_d  = (is_signed_c && bus.a_in[WIDTH-1]) ? -bus.a_in : bus.a_in;
         mplier_d = (is_signed_c && bus.b_in[WIDTH-1]) ? -bus.b_in : bus.b_in;
         neg_d    = is_signed_c && (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
         prod_d   = '0;
         count_d  = '0;
         state_d  = RUN;
      end

      busy_d = (state_d == RUN) || (state_d == FIX);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= MUL;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         prod_q   <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         prod_q   <= prod_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit (WIDTH = 64): vector table plus hand-written
// sequences for ignored start, back-to-back and mid-operation reset.
module tb_mul_unit;
   import mul_unit_pkg::*;

   localparam int unsigned W   = 64;
   localparam int          LAT = W + 1;

   typedef struct {
      mul_op_t      op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   logic clk;
   logic rst_n;
   mul_unit_if #(.WIDTH(W)) bus ();

   mul_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_err = 0;
   int           done_cnt = 0;
   logic [W-1:0] exp_q [$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (rst_n && bus.done === 1'b1) begin
         done_cnt++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done: got result 0x%016h expected no done", bus.result);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (bus.result !== e) begin
               n_err++;
               $display("FAIL result: got 0x%016h expected 0x%016h", bus.result, e);
            end
         end
      end
   end

   // Drive a request at a negedge; returns on the negedge after the sampling edge.
   task automatic issue(input mul_op_t op, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a_in  = a;
      bus.b_in  = b;
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
   endtask

   // Count cycles until done is seen; bounded.
   task automatic wait_done(input string name, input int exp_lat);
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_latency"}, W'(n), W'(exp_lat));
   endtask

   vec_t vecs [10];

   initial begin
      int d0;
      vecs[0] = '{MUL,   64'd5,                   64'd10,                  64'd50};
      vecs[1] = '{SMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   64'hFFFF_FFFF_FFFF_FFFF};
      vecs[2] = '{MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   64'hFFFF_FFFF_FFFF_FFFF};
      vecs[3] = '{UMULH, 64'h8000_0000_0000_0000, 64'd4,                   64'd2};
      vecs[4] = '{SMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
      vecs[5] = '{RSVD,  64'd7,                   64'd9,                   64'd63};
      vecs[6] = '{SMULH, 64'h4000_0000_0000_0000, 64'd4,                   64'd1};
      vecs[7] = '{SMULH, 64'hC000_0000_0000_0000, 64'd4,                   64'hFFFF_FFFF_FFFF_FFFF};
      vecs[8] = '{UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[9] = '{MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = MUL;
      bus.a_in  = '0;
      bus.b_in  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("reset_busy",   W'(bus.busy), '0);
      check("reset_done",   W'(bus.done), '0);
      check("reset_result", bus.result,   '0);

      // Table of single operations.
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(vecs[i].exp);
         issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
         check($sformatf("busy_start_%0d", i), W'(bus.busy), W'(1));
         wait_done($sformatf("vec_%0d", i), LAT);
         @(negedge clk);
         check($sformatf("done_fall_%0d", i), W'(bus.done), '0);
         check($sformatf("held_%0d", i), bus.result, vecs[i].exp);
         check($sformatf("idle_busy_%0d", i), W'(bus.busy), '0);
      end

      // Start during RUN is ignored.
      d0 = done_cnt;
      exp_q.push_back(64'd6);
      issue(MUL, 64'd2, 64'd3, 1'b0);
      repeat (9) @(negedge clk);
      issue(MUL, 64'd3, 64'd7, 1'b0);
      wait_done("ignored_start", LAT - 10);
      repeat (80) @(negedge clk);
      check("ignored_done_count", W'(done_cnt - d0), W'(1));
      check("ignored_result", bus.result, 64'd6);

      // Back-to-back: start held, new operands presented in the DONE cycle.
      d0 = done_cnt;
      exp_q.push_back(64'd42);
      issue(MUL, 64'd6, 64'd7, 1'b1);
      wait_done("b2b_first", LAT);
      bus.a_in = 64'hFFFF_FFFF_FFFF_FFFE;
      bus.b_in = 64'd3;
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFA);
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_busy_again", W'(bus.busy), W'(1));
      check("b2b_done_low", W'(bus.done), '0);
      wait_done("b2b_second", LAT);
      @(negedge clk);
      check("b2b_done_count", W'(done_cnt - d0), W'(2));

      // Reset mid-RUN aborts without a done.
      d0 = done_cnt;
      issue(MUL, 64'd123, 64'd456, 1'b0);
      repeat (29) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy",   W'(bus.busy), '0);
      check("abort_done",   W'(bus.done), '0);
      check("abort_result", bus.result,   '0);
      repeat (100) @(negedge clk);
      check("abort_no_done", W'(done_cnt - d0), '0);

      exp_q.push_back(64'd143);
      issue(MUL, 64'd11, 64'd13, 1'b0);
      wait_done("after_abort", LAT);
      @(negedge clk);
      check("after_abort_held", bus.result, 64'd143);

      check("scoreboard_empty", W'(exp_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
